gat_run_ctrl: RTL and testbench

Run sequencer between the register bank and the GAT core. It captures the three BRAM load-done strobes into sticky flags and fires a single-cycle start to the core once every load the selected layer needs has completed. It then times the run with a cycle counter and watchdog, and reports `gat_ready` and the debug words back to the register bank. Core sequencing is owned only by this block; the core sees just `core_start`, `core_layer`, `core_abort` and returns `core_done`.

---
 rtl/gat_ctrl_pkg.sv | 32 +++
 rtl/gat_run_ctrl_if.sv | 10 +
 rtl/gat_ld_flag.sv | 33 +++
 rtl/gat_run_ctrl.sv | 165 ++++++++++++++++
 tb/tb_gat_run_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gat_ctrl_pkg.sv
// Shared types and constants for the GAT run sequencer: FSM encoding,
// debug word field offsets and counter widths.
package gat_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } gat_state_e;

  localparam int unsigned RUN_CNT_W = 8;
  localparam int unsigned TO_CNT_W  = 8;
  localparam int unsigned CYC_CNT_W = 32;

  localparam int unsigned DBG2_STATE_LSB = 0;
  localparam int unsigned DBG2_LAYER_BIT = 3;
  localparam int unsigned DBG2_FLAG_LSB  = 4;
  localparam int unsigned DBG2_RUN_LSB   = 8;
  localparam int unsigned DBG2_TO_LSB    = 16;

  // Flag vector order is {fw, fn, fh}; layer 2 builds its H on-chip.
  function automatic logic [2:0] required_mask(input logic layer);
    if (layer) begin
      required_mask = 3'b100;
    end else begin
      required_mask = 3'b111;
    end
  endfunction

endpackage

// File: rtl/gat_run_ctrl_if.sv
// Start/abort/done handshake between the run sequencer (master) and the GAT core (slave).
interface gat_run_ctrl_if;
  logic core_start;
  logic core_layer;
  logic core_abort;
  logic core_done;

  modport master (output core_start, output core_layer, output core_abort, input core_done);
  modport slave  (input core_start, input core_layer, input core_abort, output core_done);
endinterface

// File: rtl/gat_ld_flag.sv
// Sticky load-done flag: a rising edge of the load level sets it, clr drops it,
// and an edge landing in the same cycle as clr keeps it set.
module gat_ld_flag (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_in,
  input  logic clr,
  output logic flag
);

  logic ld_q;
  logic ld_d;
  logic flag_q;
  logic flag_d;

  always_comb begin
    ld_d   = ld_in;
    flag_d = (ld_in & ~ld_q) | (flag_q & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q   <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      ld_q   <= ld_d;
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/gat_run_ctrl.sv
// GAT run sequencer: gathers BRAM load completions, fires the core for the
// selected layer, times the run with a watchdog and packs status for the register bank.
module gat_run_ctrl
  import gat_ctrl_pkg::*;
#(
  parameter int unsigned TOP_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gat_layer,
  input  logic                 h_data_bram_load_done,
  input  logic                 h_node_info_bram_load_done,
  input  logic                 wgt_bram_load_done,
  gat_run_ctrl_if.master       core_if,
  output logic                 gat_ready,
  output logic [TOP_WIDTH-1:0] gat_debug_1,
  output logic [TOP_WIDTH-1:0] gat_debug_2,
  output logic [TOP_WIDTH-1:0] gat_debug_3
);

  localparam logic [CYC_CNT_W-1:0] TIMEOUT_VAL = CYC_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CYC_CNT_W-1:0] CYC_MAX     = {CYC_CNT_W{1'b1}};
  localparam logic [TO_CNT_W-1:0]  TO_MAX      = {TO_CNT_W{1'b1}};

  gat_state_e           state_q, state_d;
  logic                 layer_q, layer_d;
  logic                 start_q, start_d;
  logic                 abort_q, abort_d;
  logic                 ready_q, ready_d;
  logic [CYC_CNT_W-1:0] cnt_q, cnt_d;
  logic [CYC_CNT_W-1:0] dbg1_q, dbg1_d;
  logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [TO_CNT_W-1:0]  to_cnt_q, to_cnt_d;

  logic [2:0]  flags_s;
  logic [2:0]  clr_s;
  logic [2:0]  need_s;
  logic [31:0] dbg2_s;

  // Only the flags the launching run consumed are dropped, during START.
  assign clr_s  = (state_q == ST_START) ? required_mask(layer_q) : 3'b000;
  assign need_s = required_mask(gat_layer);

  gat_ld_flag u_flag_h (
    .clk   (clk),
    .rst_n (rst_n),
    .ld_in (h_data_bram_load_done),
    .clr   (clr_s[0]),
    .flag  (flags_s[0])
  );

  gat_ld_flag u_flag_n (
    .clk   (clk),
    .rst_n (rst_n),
    .ld_in (h_node_info_bram_load_done),
    .clr   (clr_s[1]),
    .flag  (flags_s[1])
  );

  gat_ld_flag u_flag_w (
    .clk   (clk),
    .rst_n (rst_n),
    .ld_in (wgt_bram_load_done),
    .clr   (clr_s[2]),
    .flag  (flags_s[2])
  );

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    cnt_d     = cnt_q;
    dbg1_d    = dbg1_q;
    run_cnt_d = run_cnt_q;
    to_cnt_d  = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if ((flags_s & need_s) == need_s) begin
          state_d = ST_START;
          layer_d = gat_layer;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // Clear and first increment fold together so RUN cycle n reads n.
        cnt_d   = {{(CYC_CNT_W-1){1'b0}}, 1'b1};
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (core_if.core_done) begin
          state_d = ST_DONE;
        end else if ((TIMEOUT_CYCLES != 32'd0) && (cnt_q == TIMEOUT_VAL)) begin
          state_d = ST_ABORT;
        end else if (cnt_q != CYC_MAX) begin
          cnt_d = cnt_q + {{(CYC_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DONE: begin
        dbg1_d    = cnt_q;
        run_cnt_d = run_cnt_q + {{(RUN_CNT_W-1){1'b0}}, 1'b1};
        state_d   = ST_IDLE;
      end
      ST_ABORT: begin
        if (to_cnt_q != TO_MAX) begin
          to_cnt_d = to_cnt_q + {{(TO_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          to_cnt_d = to_cnt_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Pulses and ready are decoded from the next state so they line up with it.
    start_d = (state_d == ST_START);
    abort_d = (state_d == ST_ABORT);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      layer_q   <= 1'b0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      ready_q   <= 1'b1;
      cnt_q     <= {CYC_CNT_W{1'b0}};
      dbg1_q    <= {CYC_CNT_W{1'b0}};
      run_cnt_q <= {RUN_CNT_W{1'b0}};
      to_cnt_q  <= {TO_CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
      dbg1_q    <= dbg1_d;
      run_cnt_q <= run_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  always_comb begin
    dbg2_s = 32'd0;
    dbg2_s[DBG2_STATE_LSB +: 3]        = state_q;
    dbg2_s[DBG2_LAYER_BIT]             = layer_q;
    dbg2_s[DBG2_FLAG_LSB +: 3]         = flags_s;
    dbg2_s[DBG2_RUN_LSB +: RUN_CNT_W]  = run_cnt_q;
    dbg2_s[DBG2_TO_LSB +: TO_CNT_W]    = to_cnt_q;
  end

  assign core_if.core_start = start_q;
  assign core_if.core_layer = layer_q;
  assign core_if.core_abort = abort_q;
  assign gat_ready          = ready_q;
  assign gat_debug_1        = TOP_WIDTH'(dbg1_q);
  assign gat_debug_2        = TOP_WIDTH'(dbg2_s);
  assign gat_debug_3        = TOP_WIDTH'(cnt_q);

endmodule

// File: tb/tb_gat_run_ctrl.sv
// Self-checking bench for gat_run_ctrl: a cycle model derived from the run rules
// is compared on every falling edge, plus hand-computed literal checkpoints.
module tb_gat_run_ctrl;

  localparam int unsigned TO = 150;
  localparam int M_IDLE = 0, M_START = 1, M_RUN = 2, M_DONE = 3, M_ABORT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gat_layer = 1'b0;
  logic        ld_h = 1'b0, ld_n = 1'b0, ld_w = 1'b0;
  logic        gat_ready;
  logic [31:0] dbg1, dbg2, dbg3;

  int checks = 0;
  int errors = 0;

  gat_run_ctrl_if core_if ();

  gat_run_ctrl #(.TOP_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .gat_layer                  (gat_layer),
    .h_data_bram_load_done      (ld_h),
    .h_node_info_bram_load_done (ld_n),
    .wgt_bram_load_done         (ld_w),
    .core_if                    (core_if),
    .gat_ready                  (gat_ready),
    .gat_debug_1                (dbg1),
    .gat_debug_2                (dbg2),
    .gat_debug_3                (dbg3)
  );

  always #5 clk = ~clk;

  // Behavioural model: time measured as cycles elapsed since the START cycle.
  int         m_state = M_IDLE;
  bit         m_layer = 1'b0;
  bit [2:0]   m_flag = 3'b000, m_prev = 3'b000;
  longint     m_cyc = 0, m_t0 = 0;
  bit [31:0]  m_live = 32'd0, m_dbg1 = 32'd0;
  int         m_runs = 0, m_tos = 0;

  task automatic model_reset();
    m_state = M_IDLE; m_layer = 1'b0; m_flag = 3'b000; m_prev = 3'b000;
    m_live = 32'd0; m_dbg1 = 32'd0; m_runs = 0; m_tos = 0;
  endtask

  task automatic model_step();
    bit [2:0] in_v, rise, need, consumed;
    longint   el;
    in_v     = {ld_w, ld_n, ld_h};
    rise     = in_v & ~m_prev;
    consumed = (m_state == M_START) ? (m_layer ? 3'b100 : 3'b111) : 3'b000;
    m_cyc++;
    case (m_state)
      M_IDLE: begin
        need = gat_layer ? 3'b100 : 3'b111;
        if ((m_flag & need) == need) begin
          m_state = M_START;
          m_layer = gat_layer;
        end
      end
      M_START: begin
        m_t0 = m_cyc - 1;
        m_live = 32'd1;
        m_state = M_RUN;
      end
      M_RUN: begin
        if (core_if.core_done) m_state = M_DONE;
        else if (TO != 0 && m_live == TO) m_state = M_ABORT;
        else begin
          el = m_cyc - m_t0;
          m_live = (el > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(el);
        end
      end
      M_DONE: begin
        m_dbg1 = m_live;
        m_runs = (m_runs + 1) % 256;
        m_state = M_IDLE;
      end
      default: begin
        if (m_tos < 255) m_tos++;
        m_state = M_IDLE;
      end
    endcase
    m_flag = rise | (m_flag & ~consumed);
    m_prev = in_v;
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      chk("m_ready", {31'd0, gat_ready}, {31'd0, m_state == M_IDLE});
      chk("m_start", {31'd0, core_if.core_start}, {31'd0, m_state == M_START});
      chk("m_abort", {31'd0, core_if.core_abort}, {31'd0, m_state == M_ABORT});
      chk("m_layer", {31'd0, core_if.core_layer}, {31'd0, m_layer});
      chk("m_dbg1", dbg1, m_dbg1);
      chk("m_dbg2", dbg2, {8'd0, 8'(m_tos), 8'(m_runs), 1'b0, m_flag, m_layer, 3'(m_state)});
      chk("m_dbg3", dbg3, m_live);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int abort_seen;
  int abort_at;

  initial begin : stim
    core_if.core_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready", {31'd0, gat_ready}, 32'd1);
    chk("rst_dbg2", dbg2, 32'd0);
    chk("rst_dbg1", dbg1, 32'd0);

    // Layer 1 of the network: all three loads, w last.
    ld_h = 1'b1; ld_n = 1'b1;
    step(2);
    ld_w = 1'b1;
    step(1);
    chk("t1_no_start_yet", {31'd0, core_if.core_start}, 32'd0);
    step(1);
    chk("t1_start_t2", {31'd0, core_if.core_start}, 32'd1);
    chk("t1_ready_fall", {31'd0, gat_ready}, 32'd0);
    ld_h = 1'b0; ld_n = 1'b0; ld_w = 1'b0;
    step(100);
    chk("t1_cnt100", dbg3, 32'd100);
    core_if.core_done = 1'b1;
    step(1);
    core_if.core_done = 1'b0;
    step(1);
    chk("t1_dbg1", dbg1, 32'd100);
    chk("t1_runs", {24'd0, dbg2[15:8]}, 32'd1);
    chk("t1_ready", {31'd0, gat_ready}, 32'd1);

    // Layer 2: preload h/n, only w should launch, h/n survive.
    gat_layer = 1'b1;
    ld_h = 1'b1; ld_n = 1'b1;
    step(2);
    chk("t2_preload", {29'd0, dbg2[6:4]}, 32'd3);
    ld_h = 1'b0; ld_n = 1'b0; ld_w = 1'b1;
    step(2);
    chk("t2_start", {31'd0, core_if.core_start}, 32'd1);
    chk("t2_layer", {31'd0, core_if.core_layer}, 32'd1);
    ld_w = 1'b0;
    step(7);
    core_if.core_done = 1'b1;
    step(1);
    core_if.core_done = 1'b0;
    step(1);
    chk("t2_dbg1", dbg1, 32'd7);
    chk("t2_hn_kept", {29'd0, dbg2[6:4]}, 32'd3);

    // Watchdog expiry with no core_done.
    ld_w = 1'b1;
    step(2);
    ld_w = 1'b0;
    abort_seen = 0; abort_at = 0;
    for (int i = 1; i <= 200; i++) begin
      step(1);
      if (core_if.core_abort) begin
        abort_seen++;
        abort_at = i;
      end
    end
    chk("t3_abort_once", abort_seen, 32'd1);
    chk("t3_abort_cycle", abort_at, 32'd151);
    chk("t3_to_cnt", {24'd0, dbg2[23:16]}, 32'd1);
    chk("t3_dbg1_kept", dbg1, 32'd7);
    chk("t3_ready", {31'd0, gat_ready}, 32'd1);

    // core_done exactly when the counter reaches the limit: DONE wins.
    ld_w = 1'b1;
    step(2);
    chk("t4_start", {31'd0, core_if.core_start}, 32'd1);
    ld_w = 1'b0;
    step(150);
    chk("t4_cnt_at_limit", dbg3, 32'd150);
    core_if.core_done = 1'b1;
    step(1);
    core_if.core_done = 1'b0;
    chk("t4_no_abort", {31'd0, core_if.core_abort}, 32'd0);
    chk("t4_state_done", {29'd0, dbg2[2:0]}, 32'd3);
    step(1);
    chk("t4_dbg1", dbg1, 32'd150);
    chk("t4_runs", {24'd0, dbg2[15:8]}, 32'd3);

    // Preload w during a run; next run follows after one IDLE cycle.
    ld_w = 1'b1;
    step(2);
    ld_w = 1'b0;
    step(3);
    ld_w = 1'b1;
    step(2);
    chk("t5_fw_in_run", {31'd0, dbg2[6]}, 32'd1);
    ld_w = 1'b0;
    step(1);
    core_if.core_done = 1'b1;
    step(1);
    core_if.core_done = 1'b0;
    step(1);
    chk("t5_idle_gap", {31'd0, gat_ready}, 32'd1);
    step(1);
    chk("t5_back_to_back", {31'd0, core_if.core_start}, 32'd1);
    ld_w = 1'b1;
    step(1);
    chk("t5_set_wins", {31'd0, dbg2[6]}, 32'd1);
    ld_w = 1'b0;
    step(4);
    core_if.core_done = 1'b1;
    step(1);
    core_if.core_done = 1'b0;
    step(2);
    chk("t5_restart", {31'd0, core_if.core_start}, 32'd1);

    // Asynchronous reset in the middle of a run.
    step(5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ready", {31'd0, gat_ready}, 32'd1);
    chk("t6_start", {31'd0, core_if.core_start}, 32'd0);
    chk("t6_abort", {31'd0, core_if.core_abort}, 32'd0);
    chk("t6_layer", {31'd0, core_if.core_layer}, 32'd0);
    chk("t6_dbg1", dbg1, 32'd0);
    chk("t6_dbg2", dbg2, 32'd0);
    chk("t6_dbg3", dbg3, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    core_if.core_done = 1'b1;
    step(1);
    core_if.core_done = 1'b0;
    step(2);
    chk("t6_stray_done", dbg2, 32'd0);
    chk("t6_ready_after", {31'd0, gat_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
